// File: rtl/ram_arbiter.sv
// Three-way arbiter for the shared 64K single-port RAM: flash loader during boot,
// then CPU with a bounded-deferral diagnostics port; one registered access per GRANT/ACK pair.
`timescale 1ns/1ps

// state | meaning
// IDLE  | pick an eligible requester, latch its access onto the RAM pins
// GRANT | ram_cs high for this one cycle, RAM performs the access
// ACK   | ram_cs low, one-cycle ack to the owner, read data valid on RAM output
module ram_arbiter #(
    parameter int DIAG_MAX_WAIT = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        boot_done,
    input  logic        halt,
    input  logic        flash_req,
    input  logic        cpu_req,
    input  logic        diag_req,
    input  logic        flash_we,
    input  logic        cpu_we,
    input  logic        diag_we,
    input  logic [15:0] flash_addr,
    input  logic [15:0] cpu_addr,
    input  logic [15:0] diag_addr,
    input  logic [7:0]  flash_wdata,
    input  logic [7:0]  cpu_wdata,
    input  logic [7:0]  diag_wdata,
    output logic        flash_ack,
    output logic        cpu_ack,
    output logic        diag_ack,
    output logic [15:0] ram_address,
    output logic [7:0]  ram_datain,
    output logic        ram_cs,
    output logic        ram_we,
    output logic [1:0]  grant
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_GRANT = 2'd1;
    localparam logic [1:0] ST_ACK   = 2'd2;

    localparam logic [1:0] OWN_NONE  = 2'd0;
    localparam logic [1:0] OWN_FLASH = 2'd1;
    localparam logic [1:0] OWN_CPU   = 2'd2;
    localparam logic [1:0] OWN_DIAG  = 2'd3;

    localparam int WAIT_W = (DIAG_MAX_WAIT < 1) ? 1 : $clog2(DIAG_MAX_WAIT + 1);
    localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(DIAG_MAX_WAIT);

    logic [1:0]        r_state;
    logic [WAIT_W-1:0] r_wait;

    logic [1:0]  w_sel;
    logic        w_diag_due;
    logic        w_sel_we;
    logic [15:0] w_sel_addr;
    logic [7:0]  w_sel_wdata;

    assign w_diag_due = (r_wait >= WAIT_MAX);

    // Boot phase belongs to flash alone; halt hands the RAM to diagnostics alone.
    always_comb begin
        w_sel = OWN_NONE;
        if (!boot_done) begin
            if (flash_req) w_sel = OWN_FLASH;
        end else if (halt) begin
            if (diag_req) w_sel = OWN_DIAG;
        end else if (diag_req && (w_diag_due || !cpu_req)) begin
            w_sel = OWN_DIAG;
        end else if (cpu_req) begin
            w_sel = OWN_CPU;
        end
    end

    always_comb begin
        w_sel_we    = 1'b0;
        w_sel_addr  = 16'h0000;
        w_sel_wdata = 8'h00;
        case (w_sel)
            OWN_FLASH: begin
                w_sel_we    = flash_we;
                w_sel_addr  = flash_addr;
                w_sel_wdata = flash_wdata;
            end
            OWN_CPU: begin
                w_sel_we    = cpu_we;
                w_sel_addr  = cpu_addr;
                w_sel_wdata = cpu_wdata;
            end
            OWN_DIAG: begin
                w_sel_we    = diag_we;
                w_sel_addr  = diag_addr;
                w_sel_wdata = diag_wdata;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= ST_IDLE;
            grant       <= OWN_NONE;
            ram_cs      <= 1'b0;
            ram_we      <= 1'b0;
            ram_address <= 16'h0000;
            ram_datain  <= 8'h00;
            flash_ack   <= 1'b0;
            cpu_ack     <= 1'b0;
            diag_ack    <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_sel != OWN_NONE) begin
                        ram_cs      <= 1'b1;
                        ram_we      <= w_sel_we;
                        ram_address <= w_sel_addr;
                        ram_datain  <= w_sel_wdata;
                        grant       <= w_sel;
                        r_state     <= ST_GRANT;
                    end else begin
                        ram_cs <= 1'b0;
                        ram_we <= 1'b0;
                        grant  <= OWN_NONE;
                    end
                end
                ST_GRANT: begin
                    ram_cs    <= 1'b0;
                    ram_we    <= 1'b0;
                    flash_ack <= (grant == OWN_FLASH);
                    cpu_ack   <= (grant == OWN_CPU);
                    diag_ack  <= (grant == OWN_DIAG);
                    r_state   <= ST_ACK;
                end
                ST_ACK: begin
                    flash_ack <= 1'b0;
                    cpu_ack   <= 1'b0;
                    diag_ack  <= 1'b0;
                    grant     <= OWN_NONE;
                    r_state   <= ST_IDLE;
                end
                default: begin
                    ram_cs    <= 1'b0;
                    ram_we    <= 1'b0;
                    flash_ack <= 1'b0;
                    cpu_ack   <= 1'b0;
                    diag_ack  <= 1'b0;
                    grant     <= OWN_NONE;
                    r_state   <= ST_IDLE;
                end
            endcase
        end
    end

    // Counts arbitration rounds a pending diag request lost; a dropped request starts over.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wait <= '0;
        end else if (!diag_req) begin
            r_wait <= '0;
        end else if (r_state == ST_IDLE) begin
            if (w_sel == OWN_DIAG) begin
                r_wait <= '0;
            end else if (r_wait != WAIT_MAX) begin
                r_wait <= r_wait + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_ram_arbiter.sv
// Directed bench for ram_arbiter: a timeline model of expected RAM-pin activity
// is compared every cycle, plus literal checks for each scenario.
`timescale 1ns/1ps

module tb_ram_arbiter;

    localparam int MAXW = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic        boot_done, halt;
    logic        flash_req, cpu_req, diag_req;
    logic        flash_we, cpu_we, diag_we;
    logic [15:0] flash_addr, cpu_addr, diag_addr;
    logic [7:0]  flash_wdata, cpu_wdata, diag_wdata;
    logic        flash_ack, cpu_ack, diag_ack;
    logic [15:0] ram_address;
    logic [7:0]  ram_datain;
    logic        ram_cs, ram_we;
    logic [1:0]  grant;

    int checks   = 0;
    int failures = 0;

    ram_arbiter #(.DIAG_MAX_WAIT(MAXW)) dut (
        .clk(clk), .rst(rst), .boot_done(boot_done), .halt(halt),
        .flash_req(flash_req), .cpu_req(cpu_req), .diag_req(diag_req),
        .flash_we(flash_we), .cpu_we(cpu_we), .diag_we(diag_we),
        .flash_addr(flash_addr), .cpu_addr(cpu_addr), .diag_addr(diag_addr),
        .flash_wdata(flash_wdata), .cpu_wdata(cpu_wdata), .diag_wdata(diag_wdata),
        .flash_ack(flash_ack), .cpu_ack(cpu_ack), .diag_ack(diag_ack),
        .ram_address(ram_address), .ram_datain(ram_datain),
        .ram_cs(ram_cs), .ram_we(ram_we), .grant(grant)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: each access is a fixed timeline (access cycle, ack cycle, idle cycle);
    // a new arbitration happens only on an edge that ends an idle cycle.
    typedef struct {
        logic       cs;
        logic       we;
        logic [1:0] grant;
        logic [2:0] ack;   // {diag, cpu, flash}
    } rec_t;

    rec_t        plan[$];
    rec_t        m_cur;
    int          m_wait = 0;
    int          m_sel;
    logic        e_cs = 0, e_we = 0;
    logic [1:0]  e_grant = 0;
    logic [2:0]  e_ack = 0;
    logic [15:0] e_addr = 0;
    logic [7:0]  e_data = 0;
    logic        live = 0;

    function automatic int pick();
        if (!boot_done) return flash_req ? 1 : 0;
        if (halt) return diag_req ? 3 : 0;
        if (diag_req && (m_wait >= MAXW || !cpu_req)) return 3;
        if (cpu_req) return 2;
        return 0;
    endfunction

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            plan.delete();
            m_wait  = 0;
            e_cs    = 0; e_we = 0; e_grant = 0; e_ack = 0;
            e_addr  = 0; e_data = 0;
        end else begin
            if (plan.size() != 0) begin
                m_cur = plan.pop_front();
            end else begin
                m_sel = pick();
                if (diag_req && m_sel != 3) m_wait = (m_wait < MAXW) ? m_wait + 1 : m_wait;
                else m_wait = 0;
                m_cur = '{cs: 1'b0, we: 1'b0, grant: 2'd0, ack: 3'b000};
                if (m_sel != 0) begin
                    case (m_sel)
                        1: begin m_cur.we = flash_we; e_addr = flash_addr; e_data = flash_wdata; end
                        2: begin m_cur.we = cpu_we;   e_addr = cpu_addr;   e_data = cpu_wdata;   end
                        default: begin m_cur.we = diag_we; e_addr = diag_addr; e_data = diag_wdata; end
                    endcase
                    m_cur.cs    = 1'b1;
                    m_cur.grant = 2'(m_sel);
                    plan.push_back('{cs: 1'b0, we: 1'b0, grant: 2'(m_sel), ack: 3'(1 << (m_sel - 1))});
                    plan.push_back('{cs: 1'b0, we: 1'b0, grant: 2'd0, ack: 3'b000});
                end
            end
            if (!diag_req) m_wait = 0;
            e_cs = m_cur.cs; e_we = m_cur.we; e_grant = m_cur.grant; e_ack = m_cur.ack;
        end
        live = 1;
    end

    always @(negedge clk) begin
        if (live) begin
            chk("cyc_grant", 32'(grant), 32'(e_grant));
            chk("cyc_cs", 32'(ram_cs), 32'(e_cs));
            chk("cyc_we", 32'(ram_we), 32'(e_we));
            chk("cyc_acks", 32'({diag_ack, cpu_ack, flash_ack}), 32'(e_ack));
            chk("cyc_addr", 32'(ram_address), 32'(e_addr));
            chk("cyc_data", 32'(ram_datain), 32'(e_data));
            chk("one_ack_max", 32'(($countones({diag_ack, cpu_ack, flash_ack}) <= 1)), 32'd1);
            chk("we_only_in_cs", 32'((!ram_we || ram_cs)), 32'd1);
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drop_all();
        flash_req = 0; cpu_req = 0; diag_req = 0;
    endtask

    int n_cpu, n_flash;
    bit found;

    initial begin
        rst = 0; boot_done = 0; halt = 0;
        flash_req = 0; cpu_req = 0; diag_req = 0;
        flash_we = 0; cpu_we = 0; diag_we = 0;
        flash_addr = 0; cpu_addr = 0; diag_addr = 0;
        flash_wdata = 0; cpu_wdata = 0; diag_wdata = 0;

        step(2);
        @(negedge clk);
        chk("rst_grant", 32'(grant), 32'd0);
        chk("rst_cs", 32'(ram_cs), 32'd0);
        chk("rst_addr", 32'(ram_address), 32'd0);
        chk("rst_acks", 32'({diag_ack, cpu_ack, flash_ack}), 32'd0);
        step(1);
        rst = 1;
        step(2);

        // Boot load with a competing CPU request
        flash_req = 1; flash_we = 1; flash_addr = 16'h1234; flash_wdata = 8'hA5;
        cpu_req = 1; cpu_addr = 16'h5555; cpu_we = 1; cpu_wdata = 8'h11;
        step(1); @(negedge clk);
        chk("boot_cs", 32'(ram_cs), 32'd1);
        chk("boot_we", 32'(ram_we), 32'd1);
        chk("boot_addr", 32'(ram_address), 32'h1234);
        chk("boot_data", 32'(ram_datain), 32'hA5);
        chk("boot_grant", 32'(grant), 32'd1);
        step(1); @(negedge clk);
        chk("boot_flash_ack", 32'(flash_ack), 32'd1);
        chk("boot_cpu_ack", 32'(cpu_ack), 32'd0);
        step(1);
        flash_req = 0;
        n_cpu = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (cpu_ack) n_cpu++;
        end
        chk("boot_cpu_never_acked", 32'(n_cpu), 32'd0);
        step(1);
        drop_all();
        step(3);

        // CPU priority with diag forced after MAXW deferrals
        boot_done = 1; halt = 0;
        cpu_req = 1; diag_req = 1; diag_we = 1; diag_addr = 16'hD00D; diag_wdata = 8'h5A;
        n_cpu = 0; found = 0;
        for (int i = 0; i < 60 && !found; i++) begin
            @(negedge clk);
            if (diag_ack) found = 1;
            else if (cpu_ack) n_cpu++;
        end
        chk("prio_diag_acked", 32'(found), 32'd1);
        chk("prio_cpu_before_diag", 32'(n_cpu), 32'(MAXW));
        step(1);
        drop_all();
        step(3);

        // Halt: diag only, read access
        halt = 1; cpu_req = 1; diag_req = 1; diag_we = 0; diag_addr = 16'h8000; diag_wdata = 8'h3C;
        step(1); @(negedge clk);
        chk("halt_grant", 32'(grant), 32'd3);
        chk("halt_cs", 32'(ram_cs), 32'd1);
        chk("halt_we", 32'(ram_we), 32'd0);
        chk("halt_addr", 32'(ram_address), 32'h8000);
        step(1); @(negedge clk);
        chk("halt_diag_ack", 32'(diag_ack), 32'd1);
        chk("halt_cpu_ack", 32'(cpu_ack), 32'd0);
        step(1);
        drop_all();
        step(3);

        // Halt rising during a CPU access
        halt = 0; cpu_req = 1; cpu_we = 1; cpu_addr = 16'h0042; cpu_wdata = 8'h77;
        diag_req = 1;
        step(1);
        halt = 1;
        @(negedge clk);
        chk("mid_grant_cpu", 32'(grant), 32'd2);
        step(1); @(negedge clk);
        chk("mid_cpu_ack", 32'(cpu_ack), 32'd1);
        step(2); @(negedge clk);
        chk("mid_next_diag", 32'(grant), 32'd3);
        step(1); @(negedge clk);
        chk("mid_diag_ack", 32'(diag_ack), 32'd1);
        step(1);
        drop_all(); halt = 0;
        step(3);

        // Reset during GRANT abandons the access
        cpu_req = 1; cpu_we = 0; cpu_addr = 16'h00FF;
        step(1);
        rst = 0;
        #1;
        chk("rstmid_cs", 32'(ram_cs), 32'd0);
        chk("rstmid_grant", 32'(grant), 32'd0);
        chk("rstmid_we", 32'(ram_we), 32'd0);
        step(2);
        rst = 1;
        step(1); @(negedge clk);
        chk("rstmid_regrant", 32'(grant), 32'd2);
        chk("rstmid_addr", 32'(ram_address), 32'h00FF);
        step(1); @(negedge clk);
        chk("rstmid_cpu_ack", 32'(cpu_ack), 32'd1);
        step(1);
        drop_all();
        step(3);

        // boot_done rises with flash and CPU both requesting
        boot_done = 0;
        step(2);
        boot_done = 1; flash_req = 1; cpu_req = 1; cpu_addr = 16'hBEEF; cpu_we = 0;
        step(1); @(negedge clk);
        chk("bootedge_grant_cpu", 32'(grant), 32'd2);
        n_flash = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (flash_ack) n_flash++;
        end
        chk("bootedge_no_flash_ack", 32'(n_flash), 32'd0);
        step(1);
        drop_all();
        step(3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
